// File: rtl/sha256_ctrl_fsm.sv
// ============================================================================
// Module   : sha256_ctrl_fsm
// Purpose  : Registered control state machine for the SHA-256 core. It owns
//            the state register, the round counter and the block counter,
//            and drives one-hot enables into the message-schedule /
//            compression datapath. The digest-valid flag is held in DONE
//            until the host acknowledges it.
// Revision : 1.0 - initial registered-controller release
// ----------------------------------------------------------------------------
// Parameters
//   ROUNDS     compression rounds per block (minimum 2)
//   BLK_W      width of the block count and block index
//   RND_W      derived: $clog2(ROUNDS), width of round_idx
// Ports
//   clk        system clock (only clock)
//   rst        synchronous active-high reset
//   start      begin a message; honoured only in IDLE
//   n_blocks   blocks in the message; latched on accepted start, 0 -> 1
//   data_valid host word strobe; keeps the FSM in LOAD while high
//   out_ack    host has consumed the digest; releases DONE
//   abort      cancel current message (only with SHA_CTRL_ABORT_EN)
//   state      current state encoding (4 bits)
//   busy       high in every state except IDLE
//   *_en       one-hot datapath enables, one per like-named state
//   round_idx  current round 0..ROUNDS-1
//   blk_idx    current block 0..n_blocks-1
//   done       digest valid, held for every DONE cycle
// Build option
//   SHA_CTRL_ABORT_EN  when defined, adds the abort port and its behaviour
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sha256_ctrl_fsm #(
    parameter  int ROUNDS = 64,
    parameter  int BLK_W  = 8,
    localparam int RND_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] n_blocks,
    input  logic             data_valid,
    input  logic             out_ack,
`ifdef SHA_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [3:0]       state,
    output logic             busy,
    output logic             load_en,
    output logic             pad_en,
    output logic             len_en,
    output logic             prep_en,
    output logic             init_en,
    output logic             round_en,
    output logic             update_en,
    output logic [RND_W-1:0] round_idx,
    output logic [BLK_W-1:0] blk_idx,
    output logic             done
);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_LOAD   = 4'd1;
    localparam logic [3:0] c_PAD    = 4'd2;
    localparam logic [3:0] c_LEN    = 4'd3;
    localparam logic [3:0] c_PREP   = 4'd4;
    localparam logic [3:0] c_INIT   = 4'd5;
    localparam logic [3:0] c_ROUND  = 4'd6;
    localparam logic [3:0] c_UPDATE = 4'd7;
    localparam logic [3:0] c_DONE   = 4'd8;

    localparam logic [RND_W-1:0] c_RND_LAST = RND_W'(ROUNDS - 1);
    localparam logic [BLK_W-1:0] c_BLK_ONE  = BLK_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]       state_q, state_d;
    logic [RND_W-1:0] rnd_q,   rnd_d;
    logic [BLK_W-1:0] blk_q,   blk_d;
    logic [BLK_W-1:0] nblk_q,  nblk_d;   // latched block count, never 0

    logic w_abort;

`ifdef SHA_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        nblk_d  = nblk_q;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_LOAD;
                    // A zero block count still carries one (padding) block.
                    nblk_d  = (n_blocks == '0) ? c_BLK_ONE : n_blocks;
                    blk_d   = '0;
                    rnd_d   = '0;
                end
            end
            c_LOAD: begin
                if (!data_valid) begin
                    state_d = c_PAD;
                end
            end
            c_PAD:  state_d = c_LEN;
            c_LEN:  state_d = c_PREP;
            c_PREP: state_d = c_INIT;
            c_INIT: begin
                rnd_d   = '0;
                state_d = c_ROUND;
            end
            c_ROUND: begin
                // Hold at the last round so round_idx never wraps.
                if (rnd_q == c_RND_LAST) begin
                    state_d = c_UPDATE;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            c_UPDATE: begin
                if (blk_q == (nblk_q - c_BLK_ONE)) begin
                    state_d = c_DONE;
                end else begin
                    blk_d   = blk_q + 1'b1;
                    rnd_d   = '0;
                    state_d = c_INIT;
                end
            end
            c_DONE: begin
                if (out_ack) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                // Illegal encodings recover to a clean IDLE.
                state_d = c_IDLE;
                rnd_d   = '0;
                blk_d   = '0;
            end
        endcase

        // Abort beats every transition; IDLE is unaffected so a coincident
        // start is still accepted there.
        if (w_abort && (state_q != c_IDLE)) begin
            state_d = c_IDLE;
            rnd_d   = '0;
            blk_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            nblk_q  <= c_BLK_ONE;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            nblk_q  <= nblk_d;
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    assign state     = state_q;
    assign busy      = (state_q != c_IDLE);
    assign load_en   = (state_q == c_LOAD);
    assign pad_en    = (state_q == c_PAD);
    assign len_en    = (state_q == c_LEN);
    assign prep_en   = (state_q == c_PREP);
    assign init_en   = (state_q == c_INIT);
    assign round_en  = (state_q == c_ROUND);
    assign update_en = (state_q == c_UPDATE);
    assign done      = (state_q == c_DONE);
    assign round_idx = rnd_q;
    assign blk_idx   = blk_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_ctrl_fsm.sv
// ============================================================================
// Module   : tb_sha256_ctrl_fsm
// Purpose  : Self-checking bench for sha256_ctrl_fsm. Two instances are
//            used: the default build (ROUNDS=64, BLK_W=8) and a small build
//            (ROUNDS=4, BLK_W=2). Expected per-cycle behaviour is produced
//            by a phase-list model built from the message parameters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_ctrl_fsm;

    localparam int RA = 64;
    localparam int BA = 8;
    localparam int RB = 4;
    localparam int BB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       dv, ack;
    logic [7:0] nb;
`ifdef SHA_CTRL_ABORT_EN
    logic       abort_s;
`endif

    logic [3:0] st_a, st_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic       ld_a, pd_a, ln_a, pr_a, in_a, rd_a, up_a;
    logic       ld_b, pd_b, ln_b, pr_b, in_b, rd_b, up_b;
    logic [5:0] rnd_a;
    logic [1:0] rnd_b;
    logic [7:0] blk_a;
    logic [1:0] blk_b;

    always #5 clk = ~clk;

    sha256_ctrl_fsm #(.ROUNDS(RA), .BLK_W(BA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .n_blocks(nb),
        .data_valid(dv), .out_ack(ack),
`ifdef SHA_CTRL_ABORT_EN
        .abort(abort_s),
`endif
        .state(st_a), .busy(busy_a),
        .load_en(ld_a), .pad_en(pd_a), .len_en(ln_a), .prep_en(pr_a),
        .init_en(in_a), .round_en(rd_a), .update_en(up_a),
        .round_idx(rnd_a), .blk_idx(blk_a), .done(done_a)
    );

    sha256_ctrl_fsm #(.ROUNDS(RB), .BLK_W(BB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .n_blocks(nb[1:0]),
        .data_valid(dv), .out_ack(ack),
`ifdef SHA_CTRL_ABORT_EN
        .abort(abort_s),
`endif
        .state(st_b), .busy(busy_b),
        .load_en(ld_b), .pad_en(pd_b), .len_en(ln_b), .prep_en(pr_b),
        .init_en(in_b), .round_en(rd_b), .update_en(up_b),
        .round_idx(rnd_b), .blk_idx(blk_b), .done(done_b)
    );

    // Observation mux: sel picks which instance is being examined.
    int          sel = 0;
    logic [31:0] o_st, o_busy, o_en, o_rnd, o_blk, o_done;

    always_comb begin
        if (sel == 0) begin
            o_st   = 32'(st_a);
            o_busy = 32'(busy_a);
            o_en   = 32'({up_a, rd_a, in_a, pr_a, ln_a, pd_a, ld_a});
            o_rnd  = 32'(rnd_a);
            o_blk  = 32'(blk_a);
            o_done = 32'(done_a);
        end else begin
            o_st   = 32'(st_b);
            o_busy = 32'(busy_b);
            o_en   = 32'({up_b, rd_b, in_b, pr_b, ln_b, pd_b, ld_b});
            o_rnd  = 32'(rnd_b);
            o_blk  = 32'(blk_b);
            o_done = 32'(done_b);
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int st;
        int rnd;   // -1: not compared
        int blk;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the state/counters the model expects.
    task automatic check_out(input string tag, input int s, input int rnd, input int blk);
        int exp_en;
        exp_en = (s >= 1 && s <= 7) ? (1 << (s - 1)) : 0;
        chk({tag, ".state"}, o_st, s);
        chk({tag, ".busy"},  o_busy, (s != 0) ? 1 : 0);
        chk({tag, ".en"},    o_en, exp_en);
        chk({tag, ".done"},  o_done, (s == 8) ? 1 : 0);
        if (rnd >= 0) chk({tag, ".round_idx"}, o_rnd, rnd);
        if (blk >= 0) chk({tag, ".blk_idx"},   o_blk, blk);
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    // One full message: L data words, nb_in requested blocks, host leaves
    // the digest unacknowledged for K DONE cycles.
    task automatic run_msg(input int s, input int L, input int nb_in, input int K);
        exp_t q[$];
        int   r, n, cyc;
        bit   first_done;
        r   = (s != 0) ? RB : RA;
        n   = (nb_in == 0) ? 1 : nb_in;
        sel = s;
        nb  = 8'(nb_in);
        dv  = 1'($urandom);
        ack = 1'($urandom);
        set_start(1'b1);
        tick();

        // Phase list of the whole message, cycle by cycle after acceptance.
        for (int j = 0; j <= L; j++) q.push_back('{1, 0, 0});
        q.push_back('{2, 0, 0});
        q.push_back('{3, 0, 0});
        q.push_back('{4, 0, 0});
        for (int b = 0; b < n; b++) begin
            q.push_back('{5, -1, b});
            for (int k = 0; k < r; k++) q.push_back('{6, k, b});
            q.push_back('{7, r - 1, b});
        end
        for (int k = 0; k <= K; k++) q.push_back('{8, r - 1, n - 1});

        cyc        = 1;
        first_done = 1'b1;
        for (int idx = 0; idx < q.size(); idx++) begin
            check_out($sformatf("m%0d.c%0d", s, cyc), q[idx].st, q[idx].rnd, q[idx].blk);
            if (first_done && o_done === 32'd1) begin
                chk("done_latency", 32'(cyc), L + 5 + n * (r + 2));
                first_done = 1'b0;
            end
            // Inputs for the edge that ends this cycle; start and ack are
            // noise outside IDLE / DONE respectively.
            dv  = (q[idx].st == 1) ? (idx < L) : 1'($urandom);
            ack = (q[idx].st == 8) ? (idx == q.size() - 1) : 1'($urandom);
            set_start(1'($urandom));
            tick();
            cyc++;
        end
        set_start(1'b0);
        check_out($sformatf("m%0d.end", s), 0, -1, -1);
    endtask

    initial begin
        bit found;
        bit any_done;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        dv      = 1'b0;
        ack     = 1'b0;
        nb      = 8'd0;
`ifdef SHA_CTRL_ABORT_EN
        abort_s = 1'b0;
`endif
        tick();
        tick();
        sel = 0; check_out("rst_a", 0, 0, 0);
        sel = 1; check_out("rst_b", 0, 0, 0);
        rst = 1'b0;
        tick();

        // Directed scenarios
        run_msg(0, 0, 1, 0);     // single block, immediate ack
        run_msg(0, 16, 3, 3);    // three blocks, 16 data words
        run_msg(1, 0, 0, 0);     // small build, zero count -> one block
        run_msg(0, 2, 1, 10);    // ack held off 10 cycles, start noise in DONE
        run_msg(1, 1, 3, 2);     // small build, maximum block count

        // Randomized messages
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1)
                run_msg(1, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4));
            else
                run_msg(0, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset in the middle of ROUND 30
        sel     = 0;
        nb      = 8'd2;
        dv      = 1'b0;
        ack     = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (o_st === 32'd6 && o_rnd === 32'd30) found = 1'b1;
            else tick();
        end
        chk("reach_round30", 32'(found), 1);
        rst = 1'b1;
        tick();
        check_out("mid_rst", 0, 0, 0);
        rst = 1'b0;
        run_msg(0, 1, 2, 1);

`ifdef SHA_CTRL_ABORT_EN
        // Abort in UPDATE of block 1 of 2
        sel      = 0;
        nb       = 8'd2;
        dv       = 1'b0;
        ack      = 1'b0;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        found    = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (o_done === 32'd1) any_done = 1'b1;
            if (o_st === 32'd7 && o_blk === 32'd1) found = 1'b1;
            else tick();
        end
        chk("reach_update_b1", 32'(found), 1);
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        check_out("abort", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (o_done === 32'd1) any_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(any_done), 0);

        // Abort together with start in IDLE: start wins
        abort_s = 1'b1;
        start_a = 1'b1;
        tick();
        abort_s = 1'b0;
        start_a = 1'b0;
        chk("abort_idle_start", o_st, 1);
`else
        found    = 1'b0;
        any_done = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha256_ctrl_fsm.md
# sha256_ctrl_fsm

Registered control state machine for the SHA-256 core, successor to the combinational next-state decoder. It holds the state register and the round and block counters, so the datapath no longer supplies `finish_loop` or `is_zero`. It is parametrised in round count and block-count width, and holds `done` until the host acknowledges it. It sits between the host interface and the message-schedule/compression datapath, driving all datapath enables.

## Interface
- `ROUNDS`, 64, compression rounds per block; minimum 2.
- `BLK_W`, 8, width of the block count and block index.
- `RND_W` is a derived localparam, equal to `$clog2(ROUNDS)`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  begin a message; sampled only in IDLE.
- `n_blocks`  in  BLK_W  number of 512-bit blocks; latched on the accepted `start`; 0 is treated as 1.
- `data_valid`  in  1  host word strobe during LOAD.
- `out_ack`  in  1  host has taken the digest.
- `abort`  in  1  cancel the message; present only with `SHA_CTRL_ABORT_EN`.
- `state`  out  4  current state encoding.
- `busy`  out  1  high in every state except IDLE.
- `load_en`, `pad_en`, `len_en`, `prep_en`, `init_en`, `round_en`, `update_en`  out  1 each  one-hot datapath enables, one per like-named state.
- `round_idx`  out  RND_W  current round, 0..ROUNDS-1.
- `blk_idx`  out  BLK_W  current block, 0..n_blocks-1.
- `done`  out  1  digest valid; held until acknowledged.

## Operation
State encodings: IDLE=0, LOAD=1, PAD=2, LEN=3, PREP=4, INIT=5, ROUND=6, UPDATE=7, DONE=8. Encodings 9..15 are illegal and go to IDLE on the next cycle.

Transitions:
- IDLE: `start`=1 → LOAD. On the same edge, latch `n_blocks` (0 becomes 1) and clear `blk_idx` and `round_idx`.
- LOAD: `data_valid`=1 → stay in LOAD; `data_valid`=0 → PAD.
- PAD → LEN → PREP → INIT, unconditionally, one cycle each.
- INIT: `round_idx` is cleared to 0 → ROUND.
- ROUND: `round_idx` increments every cycle. When `round_idx`==ROUNDS-1 → UPDATE; `round_idx` does not wrap past ROUNDS-1.
- UPDATE: if `blk_idx`==latched count-1 → DONE; otherwise increment `blk_idx` and → INIT.
- DONE: `out_ack`=1 → IDLE; otherwise stay in DONE.

Rules:
- `start` is ignored in every state except IDLE.
- Counter arithmetic is unsigned and the width is fixed by its parameter. Block count 2^BLK_W-1 is the maximum supported value.
- `rst` has priority over every other input, including `abort`.

## Timing
- All outputs are decoded from registered state and counters (Moore outputs). No output depends combinationally on an input.
- On reset: `state`=0, `busy`=0, all enables 0, `round_idx`=0, `blk_idx`=0, `done`=0, latched count=1.
- Latency: `start` accepted at cycle T, with L cycles of `data_valid`=1 and N blocks. `done` first goes high at cycle T + L + 5 + N·(ROUNDS+2).
- Each block takes INIT (1 cycle) + ROUNDS + UPDATE (1 cycle).
- `done` is high for every cycle spent in DONE. If `out_ack` is high in the first DONE cycle, `done` is high for exactly one cycle.
- `rst` asserted mid-message returns the block to IDLE on the next edge, with every output at its reset value.

## Configuration
- `SHA_CTRL_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in any non-IDLE state sends the FSM to IDLE on the next edge and clears both counters.
  - `abort` overrides all transitions except `rst`.
  - `done` is not asserted for an aborted message.
  - `abort` in IDLE has no effect, even if `start` is high in the same cycle; `start` is then accepted.
- Not defined: the port is absent and the FSM behaves as if `abort` were tied to 0.

## Test plan
- Reset, then `start` with `n_blocks`=1, `data_valid` low, `out_ack` held high → sequence 0,1,2,3,4,5,6×64,7,8,0. `done` high only at T+71; `round_idx` runs 0..63.
- `n_blocks`=3, `data_valid` high for 16 cycles → `blk_idx` reads 0,1,2. `done` at T+16+5+3·66 = T+219. Exactly three INIT pulses.
- Build with ROUNDS=4, BLK_W=2, `n_blocks`=0 → treated as 1. `done` at T+11. `round_idx` reaches 3 and never wraps.
- `out_ack` low for 10 cycles after DONE → `done` stays high and `state` stays 8. `start` pulses during DONE are ignored. `out_ack`=1 → IDLE on the next cycle.
- `rst` during ROUND with `round_idx`=30 → all outputs at reset values on the next cycle. The following `start` restarts from `blk_idx`=0.
- With `SHA_CTRL_ABORT_EN`: `abort` during UPDATE of block 1 of 2 → IDLE on the next cycle, `done` never asserted. `abort` together with `start` in IDLE → LOAD.
